pmp_req_arbiter: RTL and testbench

PMP_REQ_ARBITER -- requirements
Module: pmp_req_arbiter

---
 rtl/pmp_pkg.sv | 35 +++
 rtl/pmp_rr_arb2.sv | 19 +
 rtl/pmp_req_arbiter.sv | 172 +++++++++++++++++
 tb/tb_pmp_req_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_pkg.sv
// Shared PMP definitions: access-type encodings and fault-cause constants
// used by the request arbiter and anything that talks to the PMP checker.
`timescale 1ns/1ps
package pmp_pkg;

   typedef enum logic [1:0] {
      ACC_R   = 2'b00,
      ACC_W   = 2'b01,
      ACC_X   = 2'b10,
      ACC_RSV = 2'b11
   } acc_type_e;

   typedef enum logic [1:0] {
      CAUSE_NONE,
      CAUSE_DENIED,
      CAUSE_TIMEOUT,
      CAUSE_RESERVED
   } fault_cause_e;

   typedef struct packed {
      logic fault;
      logic timeout;
   } resp_flags_t;

   // Widest timer needed for the largest legal timeout (64 cycles).
   localparam int TIMER_W = 6;

   function automatic resp_flags_t cause_flags(fault_cause_e cause);
      resp_flags_t f;
      f.fault   = (cause != CAUSE_NONE);
      f.timeout = (cause == CAUSE_TIMEOUT);
      return f;
   endfunction

endpackage

// File: rtl/pmp_rr_arb2.sv
// Two-way round-robin grant: a lone valid wins; on a tie the port that did
// not win last time is granted.
`timescale 1ns/1ps
module pmp_rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = 2'b00;
      if (valid_i[0] && (!valid_i[1] || last_grant_i)) begin
         grant_o = 2'b01;
      end else if (valid_i[1]) begin
         grant_o = 2'b10;
      end
   end

endmodule

// File: rtl/pmp_req_arbiter.sv
// Shares one PMP checker between the instruction (port 0) and data (port 1)
// requesters, one transaction at a time, with a checker-response timeout.
`timescale 1ns/1ps
module pmp_req_arbiter
   import pmp_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [1:0]        req0_type,
   output logic              resp0_valid,
   input  logic              resp0_ready,
   output logic              resp0_fault,
   output logic              resp0_timeout,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [1:0]        req1_type,
   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic              resp1_fault,
   output logic              resp1_timeout,
   output logic              chk_valid,
   input  logic              chk_ready,
   output logic [ADDR_W-1:0] chk_addr,
   output logic [1:0]        chk_type,
   input  logic              chk_resp_valid,
   input  logic              chk_fault
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYC - 1);

   state_e              state_q,      state_d;
   logic                owner_q,      owner_d;
   logic                last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]   addr_q,       addr_d;
   acc_type_e           type_q,       type_d;
   logic                chk_valid_q,  chk_valid_d;
   logic [TIMER_W-1:0]  timer_q,      timer_d;
   logic                stale_q,      stale_d;
   logic [1:0]          resp_valid_q, resp_valid_d;
   resp_flags_t         flags_q,      flags_d;

   logic [1:0] grant;
   logic       accept;
   logic       resp_live;
   logic       resp_ack;

   pmp_rr_arb2 u_arb (
      .valid_i      ({req1_valid, req0_valid}),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   assign accept    = (state_q == S_IDLE) && (grant != 2'b00);
   assign resp_live = chk_resp_valid && !stale_q;
   assign resp_ack  = owner_q ? resp1_ready : resp0_ready;

   always_comb begin
      // NOTE: every next-state value starts as a hold of its register so no
      // path through the case below can leave one unassigned (no latches).
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      type_d       = type_q;
      chk_valid_d  = chk_valid_q;
      timer_d      = timer_q;
      stale_d      = stale_q;
      resp_valid_d = resp_valid_q;
      flags_d      = flags_q;

      // A response owed to a timed-out transaction is swallowed wherever it lands.
      if (stale_q && chk_resp_valid) begin
         stale_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d      = S_ISSUE;
               owner_d      = grant[1];
               last_grant_d = grant[1];
               addr_d       = grant[1] ? req1_addr : req0_addr;
               type_d       = acc_type_e'(grant[1] ? req1_type : req0_type);
               chk_valid_d  = (type_d != ACC_RSV);
            end
         end
         S_ISSUE: begin
            if (type_q == ACC_RSV) begin
               state_d      = S_RESP;
               flags_d      = cause_flags(CAUSE_RESERVED);
               resp_valid_d = owner_q ? 2'b10 : 2'b01;
            end else if (chk_ready) begin
               state_d     = S_WAIT;
               chk_valid_d = 1'b0;
               timer_d     = '0;
            end
         end
         S_WAIT: begin
            timer_d = timer_q + TIMER_W'(1);
            if (resp_live) begin
               state_d      = S_RESP;
               flags_d      = cause_flags(chk_fault ? CAUSE_DENIED : CAUSE_NONE);
               resp_valid_d = owner_q ? 2'b10 : 2'b01;
            end else if (timer_q == TMO_LAST) begin
               state_d      = S_RESP;
               flags_d      = cause_flags(CAUSE_TIMEOUT);
               resp_valid_d = owner_q ? 2'b10 : 2'b01;
               stale_d      = 1'b1;
            end
         end
         S_RESP: begin
            if (resp_ack) begin
               state_d      = S_IDLE;
               resp_valid_d = 2'b00;
               flags_d      = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values; the latched address/type are reset too so chk_addr
      // and chk_type never show X after reset.
      if (!rstn) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         type_q       <= ACC_R;
         chk_valid_q  <= 1'b0;
         timer_q      <= '0;
         stale_q      <= 1'b0;
         resp_valid_q <= 2'b00;
         flags_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         type_q       <= type_d;
         chk_valid_q  <= chk_valid_d;
         timer_q      <= timer_d;
         stale_q      <= stale_d;
         resp_valid_q <= resp_valid_d;
         flags_q      <= flags_d;
      end
   end

   assign req0_ready    = (state_q == S_IDLE) && grant[0];
   assign req1_ready    = (state_q == S_IDLE) && grant[1];
   assign chk_valid     = chk_valid_q;
   assign chk_addr      = addr_q;
   assign chk_type      = type_q;
   assign resp0_valid   = resp_valid_q[0];
   assign resp1_valid   = resp_valid_q[1];
   assign resp0_fault   = flags_q.fault;
   assign resp1_fault   = flags_q.fault;
   assign resp0_timeout = flags_q.timeout;
   assign resp1_timeout = flags_q.timeout;

endmodule

// File: tb/tb_pmp_req_arbiter.sv
// Self-checking bench for pmp_req_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_pmp_req_arbiter;

   localparam int TMO = 32;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_fault, resp0_timeout;
   logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_fault, resp1_timeout;
   logic [31:0] req0_addr, req1_addr, chk_addr;
   logic [1:0]  req0_type, req1_type, chk_type;
   logic        chk_valid, chk_ready, chk_resp_valid, chk_fault;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int model_last;   // port granted most recently, as the model sees it

   always #5 clk = ~clk;

   pmp_req_arbiter #(.ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_type(req0_type),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_fault(resp0_fault), .resp0_timeout(resp0_timeout),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_type(req1_type),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_fault(resp1_fault), .resp1_timeout(resp1_timeout),
      .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_addr(chk_addr), .chk_type(chk_type),
      .chk_resp_valid(chk_resp_valid), .chk_fault(chk_fault)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0;
      req0_type = 0; req1_type = 0; resp0_ready = 0; resp1_ready = 0;
      chk_ready = 0; chk_resp_valid = 0; chk_fault = 0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rstn = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) rstn = 1;
      tick();
      model_last = 1;
   endtask

   // Reference model: which port the spec's round-robin rule grants.
   function automatic int model_pick(input logic v0, input logic v1);
      if (v0 && v1) return (model_last == 0) ? 1 : 0;
      return v0 ? 0 : 1;
   endfunction

   // Reference model: expected {fault, timeout} and WAIT residency for a transaction
   // whose checker answers on WAIT cycle d (d >= TMO means never).
   function automatic logic [1:0] model_flags(input logic [1:0] t, input int d, input logic flt);
      if (t == 2'b11) return 2'b10;
      if (d < TMO)    return {flt, 1'b0};
      return 2'b11;
   endfunction

   function automatic int model_wait(input logic [1:0] t, input int d);
      if (t == 2'b11) return 0;
      return (d < TMO) ? d + 1 : TMO;
   endfunction

   // Drives one transaction end to end and reports what the DUT did.
   task automatic run_one(
      input  logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] a1,
      input  logic [1:0] t0, input logic [1:0] t1, input int d, input logic flt,
      input  int stale_at, input int hold,
      output int g_port, output logic [1:0] g_rv, output logic [1:0] g_ft, output int g_wait,
      output logic g_chk, output logic [31:0] g_addr, output logic [1:0] g_type, output logic g_proto_ok);
      int n;
      g_port = -1; g_rv = 0; g_ft = 0; g_wait = 0; g_proto_ok = 1;
      req0_valid = v0; req1_valid = v1; req0_addr = a0; req1_addr = a1;
      req0_type = t0; req1_type = t1;
      #1;
      if (req0_ready && req1_ready) g_port = 2;
      else if (req0_ready)          g_port = 0;
      else if (req1_ready)          g_port = 1;
      tick();
      req0_valid = 0; req1_valid = 0;
      g_chk = chk_valid; g_addr = chk_addr; g_type = chk_type;
      n = 0;
      if (chk_valid) begin
         chk_ready = 1;
         tick();
         chk_ready = 0;
         while (!(resp0_valid || resp1_valid) && n < 100) begin
            if (n == d) begin
               chk_resp_valid = 1; chk_fault = flt;
            end else if (n == stale_at) begin
               chk_resp_valid = 1; chk_fault = 1;
            end
            tick();
            chk_resp_valid = 0; chk_fault = 0;
            n++;
         end
         g_wait = n;
      end else begin
         while (!(resp0_valid || resp1_valid) && n < 100) begin
            if (chk_valid) g_chk = 1;
            tick();
            n++;
         end
      end
      g_rv = {resp1_valid, resp0_valid};
      g_ft = {resp0_valid ? resp0_fault : resp1_fault, resp0_valid ? resp0_timeout : resp1_timeout};
      for (int i = 0; i < hold; i++) begin
         req0_valid = 1; req1_valid = 1;
         #1;
         if (req0_ready || req1_ready || chk_valid || {resp1_valid, resp0_valid} !== g_rv ||
             {resp0_fault, resp0_timeout} !== g_ft || {resp1_fault, resp1_timeout} !== g_ft)
            g_proto_ok = 0;
         tick();
      end
      req0_valid = 0; req1_valid = 0;
      resp0_ready = g_rv[0]; resp1_ready = g_rv[1];
      tick();
      resp0_ready = 0; resp1_ready = 0;
      if (resp0_valid || resp1_valid) g_proto_ok = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn = 0;
      #7;
      total_cnt++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_fault, resp1_fault,
           resp0_timeout, resp1_timeout, chk_valid} !== 9'b0)
         $display("FAIL reset_outputs: got %b want 000000000", {req0_ready, req1_ready, resp0_valid,
                  resp1_valid, resp0_fault, resp1_fault, resp0_timeout, resp1_timeout, chk_valid});
      else pass_cnt++;
      apply_reset();
      total_cnt++;
      if ({resp0_valid, resp1_valid, chk_valid} !== 3'b0)
         $display("FAIL reset_release: got %b want 000", {resp0_valid, resp1_valid, chk_valid});
      else pass_cnt++;
   endtask

   task automatic test_arbitration_ties();
      int p, w, exp_p; logic [1:0] rv, ft, ty; logic ck, ok; logic [31:0] ad;
      for (int k = 0; k < 3; k++) begin
         exp_p = model_pick(1, 1);
         model_last = exp_p;
         run_one(1, 1, 32'h1000 + k, 32'h2000 + k, 2'b00, 2'b01, 1, 0, -1, 0, p, rv, ft, w, ck, ad, ty, ok);
         total_cnt++;
         if (p !== exp_p || ad !== (exp_p == 0 ? 32'h1000 + k : 32'h2000 + k))
            $display("FAIL tie_grant_%0d: got port %0d addr %h want port %0d", k, p, ad, exp_p);
         else pass_cnt++;
         total_cnt++;
         if (rv !== (exp_p == 0 ? 2'b01 : 2'b10) || ft !== 2'b00 || !ok)
            $display("FAIL tie_resp_%0d: got rv=%b ft=%b ok=%b want rv for port %0d ft=00", k, rv, ft, ok, exp_p);
         else pass_cnt++;
      end
   endtask

   task automatic test_single();
      int p, w; logic [1:0] rv, ft, ty; logic ck, ok; logic [31:0] ad;
      model_last = model_pick(1, 0);
      run_one(1, 0, 32'h8000_0000, 32'h0, 2'b00, 2'b00, 3, 0, -1, 0, p, rv, ft, w, ck, ad, ty, ok);
      total_cnt++;
      if (p !== 0 || ck !== 1 || ad !== 32'h8000_0000 || ty !== 2'b00)
         $display("FAIL single_issue: got port %0d chk=%b addr=%h type=%b want 0 1 80000000 00", p, ck, ad, ty);
      else pass_cnt++;
      total_cnt++;
      if (rv !== 2'b01 || ft !== 2'b00 || w !== 4 || !ok)
         $display("FAIL single_resp: got rv=%b ft=%b wait=%0d ok=%b want rv=01 ft=00 wait=4", rv, ft, w, ok);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int p, w; logic [1:0] rv, ft, ty; logic ck, ok, seen; logic [31:0] ad;
      model_last = model_pick(0, 1);
      run_one(0, 1, 32'h0, 32'h4000, 2'b01, 2'b01, 999, 0, -1, 0, p, rv, ft, w, ck, ad, ty, ok);
      total_cnt++;
      if (rv !== 2'b10 || ft !== model_flags(2'b01, 999, 0) || w !== model_wait(2'b01, 999))
         $display("FAIL timeout_resp: got rv=%b ft=%b wait=%0d want rv=10 ft=11 wait=%0d", rv, ft, w, TMO);
      else pass_cnt++;
      // Late answer arrives while idle: must vanish without any response.
      chk_resp_valid = 1; chk_fault = 1;
      tick();
      chk_resp_valid = 0; chk_fault = 0;
      seen = resp0_valid | resp1_valid | chk_valid;
      tick();
      seen = seen | resp0_valid | resp1_valid;
      total_cnt++;
      if (seen !== 1'b0) $display("FAIL late_idle_drop: got activity=%b want 0", seen);
      else pass_cnt++;
      model_last = model_pick(0, 1);
      run_one(0, 1, 32'h0, 32'h4400, 2'b00, 2'b00, 2, 0, -1, 0, p, rv, ft, w, ck, ad, ty, ok);
      total_cnt++;
      if (rv !== 2'b10 || ft !== 2'b00 || w !== 3)
         $display("FAIL after_timeout: got rv=%b ft=%b wait=%0d want rv=10 ft=00 wait=3", rv, ft, w);
      else pass_cnt++;
      // Second timeout; this time the stale answer lands inside the next WAIT.
      model_last = model_pick(1, 0);
      run_one(1, 0, 32'h5000, 32'h0, 2'b10, 2'b00, 999, 0, -1, 0, p, rv, ft, w, ck, ad, ty, ok);
      total_cnt++;
      if (rv !== 2'b01 || ft !== 2'b11 || w !== TMO)
         $display("FAIL timeout2_resp: got rv=%b ft=%b wait=%0d want rv=01 ft=11 wait=%0d", rv, ft, w, TMO);
      else pass_cnt++;
      model_last = model_pick(1, 0);
      run_one(1, 0, 32'h5400, 32'h0, 2'b00, 2'b00, 4, 0, 0, 0, p, rv, ft, w, ck, ad, ty, ok);
      total_cnt++;
      if (rv !== 2'b01 || ft !== 2'b00 || w !== 5)
         $display("FAIL stale_in_wait: got rv=%b ft=%b wait=%0d want rv=01 ft=00 wait=5", rv, ft, w);
      else pass_cnt++;
   endtask

   task automatic test_coincident();
      int p, w; logic [1:0] rv, ft, ty; logic ck, ok; logic [31:0] ad;
      model_last = model_pick(1, 0);
      run_one(1, 0, 32'h6000, 32'h0, 2'b00, 2'b00, TMO - 1, 1, -1, 0, p, rv, ft, w, ck, ad, ty, ok);
      total_cnt++;
      if (rv !== 2'b01 || ft !== model_flags(2'b00, TMO - 1, 1) || w !== TMO)
         $display("FAIL coincident_resp: got rv=%b ft=%b wait=%0d want rv=01 ft=10 wait=%0d", rv, ft, w, TMO);
      else pass_cnt++;
      // With stale clear, an immediate answer in the next WAIT must be honoured.
      model_last = model_pick(1, 0);
      run_one(1, 0, 32'h6400, 32'h0, 2'b00, 2'b00, 0, 0, -1, 0, p, rv, ft, w, ck, ad, ty, ok);
      total_cnt++;
      if (rv !== 2'b01 || ft !== 2'b00 || w !== 1)
         $display("FAIL coincident_no_stale: got rv=%b ft=%b wait=%0d want rv=01 ft=00 wait=1", rv, ft, w);
      else pass_cnt++;
   endtask

   task automatic test_backpressure_reserved();
      int p, w; logic [1:0] rv, ft, ty; logic ck, ok; logic [31:0] ad;
      model_last = model_pick(0, 1);
      run_one(0, 1, 32'h0, 32'h7000, 2'b00, 2'b00, 1, 1, -1, 10, p, rv, ft, w, ck, ad, ty, ok);
      total_cnt++;
      if (rv !== 2'b10 || ft !== 2'b10 || !ok)
         $display("FAIL backpressure_hold: got rv=%b ft=%b stable=%b want rv=10 ft=10 stable=1", rv, ft, ok);
      else pass_cnt++;
      model_last = model_pick(1, 0);
      run_one(1, 0, 32'h7400, 32'h0, 2'b11, 2'b00, 1, 0, -1, 2, p, rv, ft, w, ck, ad, ty, ok);
      total_cnt++;
      if (ck !== 1'b0 || rv !== 2'b01 || ft !== model_flags(2'b11, 1, 0) || !ok)
         $display("FAIL reserved_type: got chk=%b rv=%b ft=%b ok=%b want chk=0 rv=01 ft=10", ck, rv, ft, ok);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int p, w, r, d, exp_p; logic [1:0] rv, ft, ty, t0, t1, exp_t; logic ck, ok, v0, v1, flt;
      logic [31:0] ad, a0, a1;
      for (int k = 0; k < 30; k++) begin
         r = $urandom_range(1, 3);
         v0 = r[0]; v1 = r[1];
         a0 = $urandom; a1 = $urandom;
         t0 = 2'($urandom_range(0, 3)); t1 = 2'($urandom_range(0, 3));
         d = $urandom_range(0, 20);
         flt = 1'($urandom_range(0, 1));
         exp_p = model_pick(v0, v1);
         model_last = exp_p;
         exp_t = (exp_p == 0) ? t0 : t1;
         run_one(v0, v1, a0, a1, t0, t1, d, flt, -1, $urandom_range(0, 3), p, rv, ft, w, ck, ad, ty, ok);
         total_cnt++;
         if (p !== exp_p || ck !== (exp_t != 2'b11) ||
             (ck && (ad !== ((exp_p == 0) ? a0 : a1) || ty !== exp_t)))
            $display("FAIL rand_issue_%0d: got port=%0d chk=%b addr=%h type=%b want port=%0d type=%b",
                     k, p, ck, ad, ty, exp_p, exp_t);
         else pass_cnt++;
         total_cnt++;
         if (rv !== ((exp_p == 0) ? 2'b01 : 2'b10) || ft !== model_flags(exp_t, d, flt) ||
             w !== model_wait(exp_t, d) || !ok)
            $display("FAIL rand_resp_%0d: got rv=%b ft=%b wait=%0d ok=%b want ft=%b wait=%0d",
                     k, rv, ft, w, ok, model_flags(exp_t, d, flt), model_wait(exp_t, d));
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_in_wait();
      int p, w; logic [1:0] rv, ft, ty; logic ck, ok, seen; logic [31:0] ad;
      req0_valid = 1; req0_addr = 32'h9000; req0_type = 2'b00;
      tick();
      req0_valid = 0; chk_ready = 1;
      tick();
      chk_ready = 0;
      tick(); tick();
      rstn = 0;
      #1;
      total_cnt++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_fault, resp1_fault,
           resp0_timeout, resp1_timeout, chk_valid} !== 9'b0)
         $display("FAIL reset_in_wait: got %b want 000000000", {req0_ready, req1_ready, resp0_valid,
                  resp1_valid, resp0_fault, resp1_fault, resp0_timeout, resp1_timeout, chk_valid});
      else pass_cnt++;
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1;
      model_last = 1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         seen = seen | resp0_valid | resp1_valid | chk_valid;
      end
      total_cnt++;
      if (seen !== 1'b0) $display("FAIL abandoned_txn: got activity=%b want 0", seen);
      else pass_cnt++;
      model_last = model_pick(1, 1);
      run_one(1, 1, 32'hA000, 32'hB000, 2'b00, 2'b00, 1, 0, -1, 0, p, rv, ft, w, ck, ad, ty, ok);
      total_cnt++;
      if (p !== 0 || rv !== 2'b01 || ft !== 2'b00)
         $display("FAIL post_reset_grant: got port=%0d rv=%b ft=%b want port=0 rv=01 ft=00", p, rv, ft);
      else pass_cnt++;
   endtask

   initial begin
      model_last = 1;
      test_reset();
      test_arbitration_ties();
      test_single();
      test_timeout();
      test_coincident();
      test_backpressure_reserved();
      test_random();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
